// File: rtl/sha256_pkg.sv
// Shared SHA-256 preprocessing definitions used by the padder and the unpadder.
package sha256_pkg;

    localparam int BLOCK_BITS      = 512;
    localparam int LEN_BITS        = 64;
    localparam int MAX_BLOCKS      = 4;
    localparam int WORD_W          = 32;

    localparam int MSG_BITS        = BLOCK_BITS * MAX_BLOCKS;
    localparam int WORDS_PER_BLOCK = BLOCK_BITS / WORD_W;
    localparam int NBLK_W          = 3;
    localparam int POS_W           = 12;
    localparam int MSG_IDX_W       = $clog2(MSG_BITS);
    localparam int WORD_SH         = $clog2(WORD_W);
    localparam int BLK_SH          = $clog2(WORDS_PER_BLOCK);
    localparam int WIDX_W          = $clog2(MAX_BLOCKS * WORDS_PER_BLOCK);
    localparam int CNT_W           = NBLK_W + BLK_SH;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        LOAD   = 3'd1,
        CHKLEN = 3'd2,
        SCAN   = 3'd3,
        DONE   = 3'd4
    } unpad_state_e;

    // Padded length P in bits for a given block count (512 * nblk).
    function automatic logic [POS_W-1:0] padded_bits(input logic [NBLK_W-1:0] nblk);
        return {nblk, 9'd0};
    endfunction

endpackage

// File: rtl/sha256_unpad_if.sv
// Request/result bundle between a padded-stream source and the unpadder.
interface sha256_unpad_if;
    import sha256_pkg::*;

    logic                  start;
    logic [MSG_BITS-1:0]   padded_in;
    logic [NBLK_W-1:0]     nblk;
    logic                  busy;
    logic                  done;
    logic [MSG_BITS-1:0]   msg_out;
    logic [LEN_BITS-1:0]   msg_len;
    logic                  err_len;
    logic                  err_pad;

    modport master (
        output start, padded_in, nblk,
        input  busy, done, msg_out, msg_len, err_len, err_pad
    );

    modport slave (
        input  start, padded_in, nblk,
        output busy, done, msg_out, msg_len, err_len, err_pad
    );

endinterface

// File: rtl/sha256_unpad_word.sv
// Combinational classifier for one scanned word: keeps message bits, and
// flags a bad marker bit or a nonzero fill bit.
module sha256_unpad_word
    import sha256_pkg::*;
(
    input  logic [WORD_W-1:0]   word,
    input  logic [POS_W-1:0]    p0,
    input  logic [LEN_BITS-1:0] len,
    input  logic [POS_W-1:0]    plen,
    output logic [WORD_W-1:0]   msg_word,
    output logic                pad_err
);

    logic [POS_W-1:0]    p_s;
    logic [LEN_BITS-1:0] p_ext_s;
    logic [POS_W-1:0]    len_field_s;
    logic                bit_s;

    // Per-bit position test; the first bit of the word (MSB) sits at p0.
    always_comb begin
        msg_word    = '0;
        pad_err     = 1'b0;
        p_s         = '0;
        p_ext_s     = '0;
        bit_s       = 1'b0;
        len_field_s = plen - POS_W'(LEN_BITS);
        for (int i = 0; i < WORD_W; i++) begin
            p_s     = p0 + POS_W'(i);
            p_ext_s = {{(LEN_BITS-POS_W){1'b0}}, p_s};
            bit_s   = word[WORD_W-1-i];
            if (p_ext_s < len) begin
                msg_word[WORD_W-1-i] = bit_s;
            end else if (p_ext_s == len) begin
                pad_err = pad_err | ~bit_s;
            end else if (p_s < len_field_s) begin
                pad_err = pad_err | bit_s;
            end else begin
                // length field: neither copied nor checked here
                pad_err = pad_err;
            end
        end
    end

endmodule

// File: rtl/sha256_unpad.sv
// SHA-256 unpadder: recovers the message and its length from 1..MAX_BLOCKS
// padded blocks, scanning one word per cycle and checking marker and fill.
module sha256_unpad
    import sha256_pkg::*;
(
    input  logic           CLK,
    input  logic           nreset,
    sha256_unpad_if.slave  bus
);

    unpad_state_e          state_r;
    unpad_state_e          state_s;

    logic [MSG_BITS-1:0]   padded_r;
    logic [NBLK_W-1:0]     nblk_r;
    logic [WIDX_W-1:0]     w_r;
    logic [MSG_BITS-1:0]   msg_out_r;
    logic [LEN_BITS-1:0]   msg_len_r;
    logic                  err_len_r;
    logic                  err_pad_r;
    logic                  busy_r;
    logic                  done_r;

    logic                  nblk_bad_s;
    logic [POS_W-1:0]      plen_s;
    logic [LEN_BITS-1:0]   len_fld_s;
    logic [LEN_BITS:0]     len_plus_s;
    logic [LEN_BITS:0]     plen_wide_s;
    logic                  len_ok_s;
    logic                  last_word_s;
    logic [MSG_IDX_W-1:0]  word_lsb_s;
    logic [POS_W-1:0]      p0_s;
    logic [WORD_W-1:0]     word_s;
    logic [WORD_W-1:0]     msg_word_s;
    logic                  pad_err_s;

    // Operand decode: block-count validity, length field, length check, word select.
    always_comb begin
        nblk_bad_s = (nblk_r == 3'd0) || (nblk_r > NBLK_W'(MAX_BLOCKS));
        plen_s     = padded_bits(nblk_r);

        len_fld_s = '0;
        for (int b = 1; b <= MAX_BLOCKS; b++) begin
            if (nblk_r == NBLK_W'(b)) begin
                len_fld_s = padded_r[MSG_BITS - b*BLOCK_BITS +: LEN_BITS];
            end else begin
                len_fld_s = len_fld_s;
            end
        end

        // 65-bit compare so a length near 2^64 cannot wrap past P
        len_plus_s  = {1'b0, msg_len_r} + 65'd65;
        plen_wide_s = {{(LEN_BITS+1-POS_W){1'b0}}, plen_s};
        len_ok_s    = (len_plus_s <= plen_wide_s) &&
                      (len_plus_s >  (plen_wide_s - 65'd512));

        last_word_s = (CNT_W'(w_r) == ({nblk_r, {BLK_SH{1'b0}}} - CNT_W'(1)));
        word_lsb_s  = MSG_IDX_W'(MSG_BITS - WORD_W) - {w_r, {WORD_SH{1'b0}}};
        p0_s        = POS_W'({w_r, {WORD_SH{1'b0}}});
        word_s      = padded_r[word_lsb_s +: WORD_W];
    end

    sha256_unpad_word u_word (
        .word     (word_s),
        .p0       (p0_s),
        .len      (msg_len_r),
        .plen     (plen_s),
        .msg_word (msg_word_s),
        .pad_err  (pad_err_s)
    );

    // State register.
    always_ff @(posedge CLK or negedge nreset) begin
        if (!nreset) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Next-state logic.
    always_comb begin
        state_s = state_r;
        case (state_r)
            IDLE: begin
                if (bus.start) state_s = LOAD;
                else           state_s = IDLE;
            end
            LOAD: begin
                if (nblk_bad_s) state_s = DONE;
                else            state_s = CHKLEN;
            end
            CHKLEN: begin
                if (len_ok_s) state_s = SCAN;
                else          state_s = DONE;
            end
            SCAN: begin
                if (last_word_s) state_s = DONE;
                else             state_s = SCAN;
            end
            DONE: begin
                if (bus.start) state_s = LOAD;
                else           state_s = DONE;
            end
            default: state_s = IDLE;
        endcase
    end

    // Datapath and status registers. Error exits raise done one cycle after
    // entering DONE, so the error flag is settled a full cycle before done.
    always_ff @(posedge CLK or negedge nreset) begin
        if (!nreset) begin
            padded_r  <= '0;
            nblk_r    <= '0;
            w_r       <= '0;
            msg_out_r <= '0;
            msg_len_r <= '0;
            err_len_r <= 1'b0;
            err_pad_r <= 1'b0;
            busy_r    <= 1'b0;
            done_r    <= 1'b0;
        end else begin
            case (state_r)
                IDLE, DONE: begin
                    if (bus.start) begin
                        padded_r  <= bus.padded_in;
                        nblk_r    <= bus.nblk;
                        w_r       <= '0;
                        msg_out_r <= '0;
                        msg_len_r <= '0;
                        err_len_r <= 1'b0;
                        err_pad_r <= 1'b0;
                        busy_r    <= 1'b1;
                        done_r    <= 1'b0;
                    end else if (state_r == DONE) begin
                        busy_r <= 1'b0;
                        done_r <= 1'b1;
                    end
                end
                LOAD: begin
                    if (nblk_bad_s) begin
                        err_len_r <= 1'b1;
                    end else begin
                        msg_len_r <= len_fld_s;
                    end
                end
                CHKLEN: begin
                    w_r <= '0;
                    if (!len_ok_s) begin
                        err_len_r <= 1'b1;
                    end
                end
                SCAN: begin
                    msg_out_r[word_lsb_s +: WORD_W] <= msg_word_s;
                    err_pad_r <= err_pad_r | pad_err_s;
                    w_r       <= w_r + WIDX_W'(1);
                    if (last_word_s) begin
                        busy_r <= 1'b0;
                        done_r <= 1'b1;
                    end
                end
                default: begin
                    busy_r <= 1'b0;
                end
            endcase
        end
    end

    assign bus.busy    = busy_r;
    assign bus.done    = done_r;
    assign bus.msg_out = msg_out_r;
    assign bus.msg_len = msg_len_r;
    assign bus.err_len = err_len_r;
    assign bus.err_pad = err_pad_r;

endmodule

// File: tb/tb_sha256_unpad.sv
// Directed testbench for sha256_unpad.
module tb_sha256_unpad;
    import sha256_pkg::*;

    logic CLK = 1'b0;
    logic nreset;

    always #5 CLK = ~CLK;

    sha256_unpad_if bus();

    sha256_unpad dut (
        .CLK    (CLK),
        .nreset (nreset),
        .bus    (bus)
    );

    int checks_total  = 0;
    int checks_passed = 0;

    // Message bits p < L kept, everything else zero.
    function automatic logic [2047:0] keep_msg(input logic [2047:0] m, input int L);
        logic [2047:0] r;
        r = '0;
        for (int p = 0; p < L && p < 2048; p++) r[2047-p] = m[2047-p];
        return r;
    endfunction

    // Reference padder: message, marker at p=L, zero fill, 64-bit L at P-64.
    function automatic logic [2047:0] pad_msg(input logic [2047:0] m, input int L, input int nb);
        logic [2047:0] r;
        logic [63:0]   lv;
        int            P;
        r  = keep_msg(m, L);
        P  = 512 * nb;
        if (L < 2048) r[2047-L] = 1'b1;
        lv = 64'(L);
        for (int i = 0; i < 64; i++) r[2047-(P-64+i)] = lv[63-i];
        return r;
    endfunction

    function automatic logic [2047:0] abc_block();
        logic [2047:0] r;
        r = '0;
        r[2047 -: 32] = 32'h61626380;
        r[1536 +: 64] = 64'd24;
        return r;
    endfunction

    function automatic logic [2047:0] abc_msg();
        logic [2047:0] r;
        r = '0;
        r[2047 -: 24] = 24'h616263;
        return r;
    endfunction

    function automatic logic [2047:0] rand_msg();
        logic [2047:0] r;
        for (int k = 0; k < 64; k++) r[k*32 +: 32] = $urandom;
        return r;
    endfunction

    // Start one operation (start sampled at edge 0) and return the edge at which done is first high.
    task automatic run_op(input logic [2047:0] pin, input logic [2:0] nb, output int edges);
        bit seen;
        @(negedge CLK);
        bus.start     = 1'b1;
        bus.padded_in = pin;
        bus.nblk      = nb;
        @(posedge CLK); #1;
        bus.start = 1'b0;
        edges = -1;
        seen  = 1'b0;
        for (int n = 1; n <= 200; n++) begin
            @(posedge CLK); #1;
            if (!seen && bus.done === 1'b1) begin
                edges = n;
                seen  = 1'b1;
            end
            if (seen) break;
        end
    endtask

    task automatic test_reset();
        bus.start = 1'b0; bus.padded_in = '0; bus.nblk = 3'd0;
        nreset = 1'b0;
        #23;
        checks_total++;
        if (bus.busy !== 1'b0 || bus.done !== 1'b0) $display("FAIL reset_status: busy=%b done=%b want 0 0", bus.busy, bus.done);
        else checks_passed++;
        checks_total++;
        if ({bus.err_len, bus.err_pad} !== 2'b00) $display("FAIL reset_err: err_len=%b err_pad=%b want 0 0", bus.err_len, bus.err_pad);
        else checks_passed++;
        checks_total++;
        if (bus.msg_len !== 64'd0 || bus.msg_out !== 2048'd0) $display("FAIL reset_data: msg_len=%0d msg_out_ones=%0d want 0 0", bus.msg_len, $countones(bus.msg_out));
        else checks_passed++;
        @(negedge CLK);
        nreset = 1'b1;
    endtask

    task automatic test_abc();
        int e;
        run_op(abc_block(), 3'd1, e);
        checks_total++;
        if (e !== 18) $display("FAIL abc_latency: done at edge %0d want 18", e);
        else checks_passed++;
        checks_total++;
        if (bus.msg_len !== 64'd24) $display("FAIL abc_len: got %0d want 24", bus.msg_len);
        else checks_passed++;
        checks_total++;
        if (bus.msg_out !== abc_msg()) $display("FAIL abc_msg: got top=%h want top=%h diffbits=%0d", bus.msg_out[2047:1984], 64'h6162630000000000, $countones(bus.msg_out ^ abc_msg()));
        else checks_passed++;
        checks_total++;
        if ({bus.err_len, bus.err_pad, bus.busy} !== 3'b000) $display("FAIL abc_flags: err_len=%b err_pad=%b busy=%b want 0 0 0", bus.err_len, bus.err_pad, bus.busy);
        else checks_passed++;
    endtask

    task automatic test_len_boundary();
        logic [2047:0] m;
        int e;
        m = rand_msg();
        // L = 447: marker directly before the length field, no fill bits
        run_op(pad_msg(m, 447, 1), 3'd1, e);
        checks_total++;
        if (e !== 18 || {bus.err_len, bus.err_pad} !== 2'b00) $display("FAIL l447_status: edge=%0d err_len=%b err_pad=%b want 18 0 0", e, bus.err_len, bus.err_pad);
        else checks_passed++;
        checks_total++;
        if (bus.msg_out !== keep_msg(m, 447) || bus.msg_len !== 64'd447) $display("FAIL l447_data: len=%0d diffbits=%0d want 447 0", bus.msg_len, $countones(bus.msg_out ^ keep_msg(m, 447)));
        else checks_passed++;
        // L = 448 does not fit one block
        run_op(pad_msg(m, 448, 1), 3'd1, e);
        checks_total++;
        if (e !== 3 || {bus.err_len, bus.err_pad} !== 2'b10) $display("FAIL l448_nblk1: edge=%0d err_len=%b err_pad=%b want 3 1 0", e, bus.err_len, bus.err_pad);
        else checks_passed++;
        // L = 448 in two blocks
        run_op(pad_msg(m, 448, 2), 3'd2, e);
        checks_total++;
        if (e !== 34 || {bus.err_len, bus.err_pad} !== 2'b00) $display("FAIL l448_nblk2: edge=%0d err_len=%b err_pad=%b want 34 0 0", e, bus.err_len, bus.err_pad);
        else checks_passed++;
        checks_total++;
        if (bus.msg_out !== keep_msg(m, 448) || bus.msg_len !== 64'd448) $display("FAIL l448_data: len=%0d diffbits=%0d want 448 0", bus.msg_len, $countones(bus.msg_out ^ keep_msg(m, 448)));
        else checks_passed++;
    endtask

    task automatic test_pad_errors();
        logic [2047:0] pin;
        int e;
        pin = abc_block();
        pin[2047-300] = 1'b1;
        run_op(pin, 3'd1, e);
        checks_total++;
        if (e !== 18 || {bus.err_len, bus.err_pad} !== 2'b01 || bus.msg_len !== 64'd24) $display("FAIL fill_flip: edge=%0d err_len=%b err_pad=%b len=%0d want 18 0 1 24", e, bus.err_len, bus.err_pad, bus.msg_len);
        else checks_passed++;
        pin = abc_block();
        pin[2047-24] = 1'b0;
        run_op(pin, 3'd1, e);
        checks_total++;
        if (e !== 18 || {bus.err_len, bus.err_pad} !== 2'b01) $display("FAIL marker_clear: edge=%0d err_len=%b err_pad=%b want 18 0 1", e, bus.err_len, bus.err_pad);
        else checks_passed++;
    endtask

    task automatic test_nblk_bad();
        int e;
        run_op(abc_block(), 3'd0, e);
        checks_total++;
        if (e !== 2 || {bus.err_len, bus.err_pad, bus.busy} !== 3'b100) $display("FAIL nblk0: edge=%0d err_len=%b err_pad=%b busy=%b want 2 1 0 0", e, bus.err_len, bus.err_pad, bus.busy);
        else checks_passed++;
        run_op(abc_block(), 3'd5, e);
        checks_total++;
        if (e !== 2 || {bus.err_len, bus.err_pad} !== 2'b10) $display("FAIL nblk5: edge=%0d err_len=%b err_pad=%b want 2 1 0", e, bus.err_len, bus.err_pad);
        else checks_passed++;
    endtask

    task automatic test_round_trip();
        int lens [14] = '{0, 1, 31, 32, 100, 446, 511, 512, 958, 959, 960, 1471, 1472, 1983};
        logic [2047:0] m;
        int nb, e;
        for (int k = 0; k < 14; k++) begin
            m  = rand_msg();
            nb = (lens[k] + 65 + 511) / 512;
            run_op(pad_msg(m, lens[k], nb), 3'(nb), e);
            checks_total++;
            if (e !== 2 + 16*nb || {bus.err_len, bus.err_pad} !== 2'b00 || bus.msg_len !== 64'(lens[k])) $display("FAIL rt_status L=%0d: edge=%0d err_len=%b err_pad=%b len=%0d want %0d 0 0 %0d", lens[k], e, bus.err_len, bus.err_pad, bus.msg_len, 2 + 16*nb, lens[k]);
            else checks_passed++;
            checks_total++;
            if (bus.msg_out !== keep_msg(m, lens[k])) $display("FAIL rt_msg L=%0d: diffbits=%0d want 0", lens[k], $countones(bus.msg_out ^ keep_msg(m, lens[k])));
            else checks_passed++;
        end
    endtask

    task automatic test_back_to_back();
        logic [2047:0] bad;
        int e;
        bad = abc_block();
        bad[2047-24] = 1'b0;
        @(negedge CLK);
        bus.start = 1'b1; bus.padded_in = abc_block(); bus.nblk = 3'd1;
        @(posedge CLK); #1;
        bus.start = 1'b0;
        repeat (5) @(posedge CLK);
        #1;
        checks_total++;
        if (bus.busy !== 1'b1 || bus.done !== 1'b0) $display("FAIL busy_mid: busy=%b done=%b want 1 0", bus.busy, bus.done);
        else checks_passed++;
        // second start while busy, with different operands
        bus.start = 1'b1; bus.padded_in = bad; bus.nblk = 3'd2;
        @(posedge CLK); #1;
        bus.start = 1'b0;
        e = -1;
        for (int n = 7; n <= 200; n++) begin
            @(posedge CLK); #1;
            if (bus.done === 1'b1) begin
                e = n;
                break;
            end
        end
        checks_total++;
        if (e !== 18 || {bus.err_len, bus.err_pad} !== 2'b00 || bus.msg_out !== abc_msg()) $display("FAIL start_ignored: edge=%0d err_len=%b err_pad=%b diffbits=%0d want 18 0 0 0", e, bus.err_len, bus.err_pad, $countones(bus.msg_out ^ abc_msg()));
        else checks_passed++;
        // a start in DONE is accepted directly
        run_op(bad, 3'd1, e);
        checks_total++;
        if (e !== 18 || {bus.err_len, bus.err_pad} !== 2'b01) $display("FAIL start_from_done: edge=%0d err_len=%b err_pad=%b want 18 0 1", e, bus.err_len, bus.err_pad);
        else checks_passed++;
    endtask

    task automatic test_reset_mid();
        int e;
        @(negedge CLK);
        bus.start = 1'b1; bus.padded_in = abc_block(); bus.nblk = 3'd1;
        @(posedge CLK); #1;
        bus.start = 1'b0;
        repeat (8) @(posedge CLK);
        #2;
        nreset = 1'b0;
        #1;
        checks_total++;
        if ({bus.busy, bus.done, bus.err_len, bus.err_pad} !== 4'b0000) $display("FAIL midreset_flags: busy=%b done=%b err_len=%b err_pad=%b want 0 0 0 0", bus.busy, bus.done, bus.err_len, bus.err_pad);
        else checks_passed++;
        checks_total++;
        if (bus.msg_len !== 64'd0 || bus.msg_out !== 2048'd0) $display("FAIL midreset_data: len=%0d msg_out_ones=%0d want 0 0", bus.msg_len, $countones(bus.msg_out));
        else checks_passed++;
        @(negedge CLK);
        nreset = 1'b1;
        run_op(abc_block(), 3'd1, e);
        checks_total++;
        if (e !== 18 || {bus.err_len, bus.err_pad} !== 2'b00 || bus.msg_out !== abc_msg()) $display("FAIL after_reset: edge=%0d err_len=%b err_pad=%b diffbits=%0d want 18 0 0 0", e, bus.err_len, bus.err_pad, $countones(bus.msg_out ^ abc_msg()));
        else checks_passed++;
    endtask

    initial begin
        test_reset();
        test_abc();
        test_len_boundary();
        test_pad_errors();
        test_nblk_bad();
        test_round_trip();
        test_back_to_back();
        test_reset_mid();
        $display("%0d/%0d checks passed", checks_passed, checks_total);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
